// File: rtl/cayde_alu_pkg.sv
// Shared definitions for the cayde ALU and its issue/execute front end:
// ALU op encoding and the RV32I opcode/funct fields the decoder recognises.
package cayde_alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_LAND = 3'd3,
        ALU_LOR  = 3'd4,
        ALU_LNOT = 3'd5
    } alu_op_e;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/cayde_alu.sv
// Combinational 32-bit ALU. Unused op codes produce zero.
module cayde_alu
    import cayde_alu_pkg::*;
(
    input  alu_op_e          op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] y
);

    logic a_nz;
    logic b_nz;

    assign a_nz = (a != '0);
    assign b_nz = (b != '0);

    // Select the operation result for the requested op.
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_XOR:  y = a ^ b;
            ALU_LAND: y = {{(ALU_W-1){1'b0}}, a_nz & b_nz};
            ALU_LOR:  y = {{(ALU_W-1){1'b0}}, a_nz | b_nz};
            ALU_LNOT: y = {{(ALU_W-1){1'b0}}, ~a_nz};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/cayde_alu_issue.sv
// Two-stage issue/execute front end for cayde_alu. Stage D holds the decoded
// op and operands, stage E holds the registered ALU result. Both stages move
// together when the output side is free, giving one op per cycle.
module cayde_alu_issue
    import cayde_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [4:0]       rd_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] ops_retired_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [4:0]      unused_rs1_idx;

    alu_op_e         dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_illegal;

    logic            d_valid;
    alu_op_e         d_op;
    logic [XLEN-1:0] d_a;
    logic [XLEN-1:0] d_b;
    logic [4:0]      d_rd;
    logic            d_illegal;

    logic            e_valid;
    logic [XLEN-1:0] e_result;
    logic [4:0]      e_rd;
    logic            e_illegal;
    logic [CNT_W-1:0] retired;

    logic [XLEN-1:0] alu_y;
    logic            e_adv;
    logic            d_adv;
    logic            in_hs;
    logic            out_hs;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    // Register indices for rs1 are resolved upstream; only the data is used.
    assign unused_rs1_idx = instr_i[19:15];

    // Decode the instruction into an ALU op and its b operand.
    always_comb begin
        dec_op      = ALU_ADD;
        dec_b       = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_b = rs2_data_i;
                if (funct3 == F3_ADD && funct7 == F7_BASE)      dec_op = ALU_ADD;
                else if (funct3 == F3_ADD && funct7 == F7_SUB)  dec_op = ALU_SUB;
                else if (funct3 == F3_XOR && funct7 == F7_BASE) dec_op = ALU_XOR;
                else if (funct3 == F3_AND && funct7 == F7_BASE) dec_op = ALU_LAND;
                else if (funct3 == F3_OR  && funct7 == F7_BASE) dec_op = ALU_LOR;
                else                                            dec_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                dec_b = imm_i;
                if (funct3 == F3_ADD)      dec_op = ALU_ADD;
                else if (funct3 == F3_XOR) dec_op = ALU_XOR;
                else                       dec_illegal = 1'b1;
            end
            OPC_CUSTOM0: begin
                if (funct3 == F3_ADD) dec_op = ALU_LNOT;
                else                  dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Illegal ops carry zero operands so nothing undefined reaches the ALU.
    assign dec_a = dec_illegal ? '0 : rs1_data_i;

    assign e_adv      = !e_valid || out_ready_i;
    assign d_adv      = d_valid && e_adv;
    assign in_ready_o = !d_valid || e_adv;
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = e_valid && out_ready_i;

    cayde_alu u_alu (
        .op (d_op),
        .a  (d_a),
        .b  (d_b),
        .y  (alu_y)
    );

    // Stage D: capture a new instruction, or drain when it moves to stage E.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_valid   <= 1'b0;
            d_op      <= ALU_ADD;
            d_a       <= '0;
            d_b       <= '0;
            d_rd      <= '0;
            d_illegal <= 1'b0;
        end else if (in_hs) begin
            d_valid   <= 1'b1;
            d_op      <= dec_op;
            d_a       <= dec_a;
            d_b       <= dec_b & {XLEN{~dec_illegal}};
            d_rd      <= instr_i[11:7];
            d_illegal <= dec_illegal;
        end else if (d_adv) begin
            d_valid   <= 1'b0;
        end
    end

    // Stage E: register the ALU result whenever the output side can move.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            e_valid   <= 1'b0;
            e_result  <= '0;
            e_rd      <= '0;
            e_illegal <= 1'b0;
        end else if (e_adv) begin
            e_valid <= d_valid;
            if (d_valid) begin
                e_result  <= d_illegal ? '0 : alu_y;
                e_rd      <= d_rd;
                e_illegal <= d_illegal;
            end
        end
    end

    // Count output handshakes, wrapping naturally at the counter width.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired <= '0;
        end else if (out_hs) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid_o   = e_valid;
    assign result_o      = e_result;
    assign rd_o          = e_rd;
    assign illegal_o     = e_illegal;
    assign ops_retired_o = retired;

endmodule

// File: tb/tb_cayde_alu_issue.sv
// Self-checking bench for cayde_alu_issue. A queue-based scoreboard tracks
// accepted instructions and their architectural results; directed scenarios
// add explicit checks against hand-derived values.
module tb_cayde_alu_issue;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [31:0]      rs1_data_i;
    logic [31:0]      rs2_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      result_o;
    logic [4:0]       rd_o;
    logic             illegal_o;
    logic [CNT_W-1:0] ops_retired_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
        int          acc_edge;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   model_cnt = 0;

    cayde_alu_issue #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .instr_i       (instr_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .result_o      (result_o),
        .rd_o          (rd_o),
        .illegal_o     (illegal_o),
        .ops_retired_o (ops_retired_o)
    );

    always #5 clk_i = ~clk_i;

    // Architectural meaning of each instruction, straight from the ISA rules.
    function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        r.rd = ins[11:7];
        r.illegal = 1'b0;
        r.result = 32'd0;
        r.acc_edge = 0;
        if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00)      r.result = a + b;
        else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) r.result = a - b;
        else if (opc == 7'h33 && f3 == 3'd4 && f7 == 7'h00) r.result = a ^ b;
        else if (opc == 7'h33 && f3 == 3'd7 && f7 == 7'h00) r.result = (a != 0 && b != 0) ? 32'd1 : 32'd0;
        else if (opc == 7'h33 && f3 == 3'd6 && f7 == 7'h00) r.result = (a != 0 || b != 0) ? 32'd1 : 32'd0;
        else if (opc == 7'h13 && f3 == 3'd0)                r.result = a + imm;
        else if (opc == 7'h13 && f3 == 3'd4)                r.result = a ^ imm;
        else if (opc == 7'h0B && f3 == 3'd0)                r.result = (a == 0) ? 32'd1 : 32'd0;
        else                                                r.illegal = 1'b1;
        return r;
    endfunction

    // One clock cycle: drive inputs, compare the visible outputs against the
    // scoreboard, then advance the model by what handshakes should occur.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input logic ordy);
        logic exp_ready;
        logic exp_valid;
        logic in_hs;
        logic out_hs;
        exp_t e;
        in_valid_i = iv;
        instr_i = ins;
        rs1_data_i = r1;
        rs2_data_i = r2;
        out_ready_i = ordy;
        #1;
        exp_ready = (q.size() < 2) || ordy;
        exp_valid = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
        checks++;
        if (in_ready_o !== exp_ready) begin
            failures++;
            $display("FAIL in_ready: got %b expected %b at %0t", in_ready_o, exp_ready, $time);
        end
        checks++;
        if (out_valid_o !== exp_valid) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid_o, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (result_o !== q[0].result || rd_o !== q[0].rd || illegal_o !== q[0].illegal) begin
                failures++;
                $display("FAIL result: got %h/rd%0d/ill%b expected %h/rd%0d/ill%b at %0t",
                         result_o, rd_o, illegal_o, q[0].result, q[0].rd, q[0].illegal, $time);
            end
        end
        checks++;
        if (ops_retired_o !== CNT_W'(model_cnt)) begin
            failures++;
            $display("FAIL ops_retired: got %0d expected %0d at %0t", ops_retired_o, CNT_W'(model_cnt), $time);
        end
        in_hs = iv && exp_ready;
        out_hs = exp_valid && ordy;
        @(posedge clk_i);
        edge_cnt++;
        if (out_hs) begin
            void'(q.pop_front());
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
        end
        if (in_hs) begin
            e = ref_exec(ins, r1, r2);
            e.acc_edge = edge_cnt;
            q.push_back(e);
        end
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        q.delete();
        model_cnt = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        instr_i = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'd0 ||
            rd_o !== 5'd0 || illegal_o !== 1'b0 || ops_retired_o !== '0) begin
            failures++;
            $display("FAIL reset_values: got rdy%b val%b res%h rd%0d ill%b cnt%0d expected 1 0 0 0 0 0",
                     in_ready_o, out_valid_o, result_o, rd_o, illegal_o, ops_retired_o);
        end
        rst_i = 1'b0;
        q.delete();
        model_cnt = 0;
    endtask

    task automatic test_add();
        step(1'b1, 32'h002081B3, 32'hFFFFFFFF, 32'd2, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h00000001 || rd_o !== 5'd3 ||
            illegal_o !== 1'b0 || ops_retired_o !== 4'd0) begin
            failures++;
            $display("FAIL add_result: got val%b res%h rd%0d ill%b cnt%0d expected 1 00000001 3 0 0",
                     out_valid_o, result_o, rd_o, illegal_o, ops_retired_o);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (ops_retired_o !== 4'd1) begin
            failures++;
            $display("FAIL add_count: got %0d expected 1", ops_retired_o);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'h402081B3, 32'd5, 32'd7, 1'b1);
        step(1'b1, 32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'hFFFFFFFE || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_sub: got val%b res%h rdy%b expected 1 fffffffe 1", out_valid_o, result_o, in_ready_o);
        end
        step(1'b1, 32'hFFF08293, 32'd0, 32'd0, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'h0FF00FF0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_xor: got val%b res%h rdy%b expected 1 0ff00ff0 1", out_valid_o, result_o, in_ready_o);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'hFFFFFFFF || rd_o !== 5'd5) begin
            failures++;
            $display("FAIL b2b_addi: got val%b res%h rd%0d expected 1 ffffffff 5", out_valid_o, result_o, rd_o);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int          start_cnt;
        start_cnt = model_cnt;
        step(1'b1, 32'h002081B3, 32'd10, 32'd1, 1'b0);
        step(1'b1, 32'h402081B3, 32'd10, 32'd1, 1'b0);
        held = result_o;
        step(1'b1, 32'h0020C1B3, 32'd10, 32'd1, 1'b0);
        checks++;
        if (in_ready_o !== 1'b0 || result_o !== held) begin
            failures++;
            $display("FAIL bp_stall: got rdy%b res%h expected 0 %h", in_ready_o, result_o, held);
        end
        step(1'b1, 32'h0020C1B3, 32'd10, 32'd1, 1'b0);
        checks++;
        if (result_o !== 32'd11 || rd_o !== 5'd3) begin
            failures++;
            $display("FAIL bp_hold: got res%h rd%0d expected 0000000b 3", result_o, rd_o);
        end
        step(1'b1, 32'h0020C1B3, 32'd10, 32'd1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (out_valid_o !== 1'b0 || ops_retired_o !== CNT_W'(start_cnt + 3)) begin
            failures++;
            $display("FAIL bp_drain: got val%b cnt%0d expected 0 %0d", out_valid_o, ops_retired_o, CNT_W'(start_cnt + 3));
        end
    endtask

    task automatic test_logic_illegal();
        step(1'b1, 32'h0020F233, 32'd4, 32'd0, 1'b1);
        step(1'b1, 32'h0020E233, 32'd0, 32'd0, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'd0 || rd_o !== 5'd4) begin
            failures++;
            $display("FAIL land: got val%b res%h rd%0d expected 1 00000000 4", out_valid_o, result_o, rd_o);
        end
        step(1'b1, 32'h0000830B, 32'd0, 32'h12345678, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'd0) begin
            failures++;
            $display("FAIL lor: got val%b res%h expected 1 00000000", out_valid_o, result_o);
        end
        step(1'b1, 32'h00000000, 32'hDEADBEEF, 32'h1, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'd1 || rd_o !== 5'd6 || illegal_o !== 1'b0) begin
            failures++;
            $display("FAIL lnot: got val%b res%h rd%0d ill%b expected 1 00000001 6 0", out_valid_o, result_o, rd_o, illegal_o);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (out_valid_o !== 1'b1 || result_o !== 32'd0 || illegal_o !== 1'b1) begin
            failures++;
            $display("FAIL illegal: got val%b res%h ill%b expected 1 00000000 1", out_valid_o, result_o, illegal_o);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3s [4];
        w = $urandom();
        f3s[0] = 3'd0; f3s[1] = 3'd4; f3s[2] = 3'd6; f3s[3] = 3'd7;
        case ($urandom_range(0, 4))
            0, 1: begin
                w[6:0] = 7'h33;
                w[14:12] = f3s[$urandom_range(0, 3)];
                case ($urandom_range(0, 3))
                    0, 1: w[31:25] = 7'h00;
                    2:    w[31:25] = 7'h20;
                    default: ;
                endcase
            end
            2: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 3) != 0) w[14:12] = f3s[$urandom_range(0, 1)];
            end
            3: begin
                w[6:0] = 7'h0B;
                if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0;
            end
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rand_operand();
        return ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
    endfunction

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_instr(), rand_operand(), rand_operand(),
                 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h002081B3, 32'd1, 32'd2, 1'b0);
        step(1'b1, 32'h002081B3, 32'd3, 32'd4, 1'b0);
        checks++;
        if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL ar_full: got val%b rdy%b expected 1 0", out_valid_o, in_ready_o);
        end
        in_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || ops_retired_o !== '0 || in_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ar_clear: got val%b cnt%0d rdy%b expected 0 0 1", out_valid_o, ops_retired_o, in_ready_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        q.delete();
        model_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 32'h00108093, i, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checks++;
        if (ops_retired_o !== 4'd1) begin
            failures++;
            $display("FAIL wrap_count: got %0d expected 1", ops_retired_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_logic_illegal();
        test_random();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
